// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one external 32-bit adder between two requesters
module add_arbiter #(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  input  logic        add_n,
  input  logic        add_z,
  input  logic        add_c,
  input  logic        add_v,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        done,
  output logic        done_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;
  logic prio, owner, grant, win;
  logic [31:0] op_a, op_b;
  always_comb begin
    grant = (state == IDLE) && (req0 || req1);
    win = (req0 && req1) ? prio : req1;
    state_nx = (state == IDLE) ? (grant ? EXEC : IDLE) : (state == EXEC) ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= INIT_PRIO;
      owner <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
      flags <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state <= state_nx;
      gnt0 <= grant && !win;
      gnt1 <= grant && win;
      done <= state == EXEC;
      if (grant) begin
        op_a <= win ? a1 : a0;
        op_b <= win ? b1 : b0;
        owner <= win;
      end
      if (state == EXEC) begin
        result <= add_sum;
        flags <= {add_n, add_z, add_c, add_v};
        done_id <= owner;
      end
      if (state == DONE) prio <= ~owner;
    end
  end
  assign add_a = op_a;
  assign add_b = op_b;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: vector table plus scoreboard of completed operations for add_arbiter
module tb_add_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, done, done_id, busy;
  logic [31:0] add_a, add_b, add_sum, result;
  logic [3:0] flags;
  logic add_n, add_z, add_c, add_v;
  logic [32:0] wide;

  always #5 clk = ~clk;

  assign wide = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum = wide[31:0];
  assign add_c = wide[32];
  assign add_n = wide[31];
  assign add_z = wide[31:0] == 32'd0;
  assign add_v = (add_a[31] == add_b[31]) && (wide[31] != add_a[31]);

  add_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_n(add_n), .add_z(add_z), .add_c(add_c), .add_v(add_v),
    .result(result), .flags(flags), .done(done), .done_id(done_id), .busy(busy)
  );

  typedef struct {
    logic r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic id;
    logic [31:0] res;
    logic [3:0] fl;
  } vec_t;

  typedef struct {
    logic id;
    logic [31:0] res;
    logic [3:0] fl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int checks = 0, errors = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_gnt(output logic id, output int n);
    logic ok = 1'b0;
    id = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        id = gnt1;
        chk("gnt_onehot", {31'd0, gnt0 && gnt1}, 32'd0);
      end
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    logic id;
    int n;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    req0 = v.r0; req1 = v.r1;
    wait_gnt(id, n);
    chk("gnt_latency", n, 32'd1);
    chk("gnt_id", {31'd0, id}, {31'd0, v.id});
    chk("add_a", add_a, v.id ? v.a1 : v.a0);
    chk("add_b", add_b, v.id ? v.b1 : v.b0);
    chk("result_hold_on_gnt", result, last_res);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    sb.push_back('{v.id, v.res, v.fl});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("done_latency", {31'd0, done}, 32'd1);
    chk("gnt_one_cycle", {30'd0, gnt1, gnt0}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_back_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic id;
    int n;
    exp_t e;
    tbl[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 32'd12, 4'b0000};
    tbl[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b0110};
    tbl[2] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 32'h8000_0000, 4'b1001};
    tbl[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd3, 32'd4, 1'b1, 32'd7, 4'b0000};
    tbl[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd50, 32'd60, 1'b0, 32'd0, 4'b0111};
    tbl[5] = '{1'b1, 1'b1, 32'd70, 32'd80, 32'hFFFF_FFFE, 32'd1, 1'b1, 32'hFFFF_FFFF, 4'b1000};
    tbl[6] = '{1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'd0, 32'd0, 1'b0, 32'h2345_6789, 4'b0000};

    fork
      forever begin
        @(negedge clk);
        if (!rst && done) begin
          if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("done_id", {31'd0, done_id}, {31'd0, e.id});
            chk("result", result, e.res);
            chk("flags", {28'd0, flags}, {28'd0, e.fl});
            last_res = e.res;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_outs", {28'd0, gnt0, gnt1, done, done_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    rst = 1'b0;

    a0 = 32'd100; b0 = 32'd1; a1 = 32'd200; b1 = 32'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(id, n);
      chk("rr_spacing", n, i == 0 ? 32'd1 : 32'd3);
      chk("rr_order", {31'd0, id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      sb.push_back('{id, id ? 32'd202 : 32'd101, 4'b0000});
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run_op(tbl[i]);

    repeat (4) begin
      @(negedge clk);
      chk("idle_quiet", {29'd0, gnt0, gnt1, done}, 32'd0);
      chk("idle_hold", result, last_res);
    end

    a0 = 32'd5; b0 = 32'd7; req0 = 1'b1;
    wait_gnt(id, n);
    req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);

    run_op('{1'b1, 1'b1, 32'd9, 32'd9, 32'd1, 32'd1, 1'b0, 32'd18, 4'b0000});
    run_op('{1'b0, 1'b1, 32'd0, 32'd0, 32'd10, 32'd20, 1'b1, 32'd30, 4'b0000});

    a1 = 32'd1; b1 = 32'd2; req1 = 1'b1;
    wait_gnt(id, n);
    chk("late_first_id", {31'd0, id}, 32'd1);
    sb.push_back('{1'b1, 32'd3, 4'b0000});
    req1 = 1'b0;
    @(negedge clk);
    chk("late_in_done", {31'd0, done}, 32'd1);
    a0 = 32'd4; b0 = 32'd4; req0 = 1'b1;
    @(negedge clk);
    chk("late_gap_busy", {31'd0, busy}, 32'd0);
    chk("late_no_gnt_yet", {31'd0, gnt0}, 32'd0);
    @(negedge clk);
    chk("late_gnt0", {31'd0, gnt0}, 32'd1);
    chk("late_busy_again", {31'd0, busy}, 32'd1);
    sb.push_back('{1'b0, 32'd8, 4'b0000});
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
Parameter:
- REQ-001 The block SHALL have parameter INIT_PRIO, default 0, which selects the requester that wins a tie after reset.

Ports (clock and reset first):
- REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
- REQ-003 rst  input  1  Reset, synchronous and active-high.
- REQ-004 req0, req1  input  1 each  Request from requester 0 or 1; held high until that requester's grant.
- REQ-005 a0, b0, a1, b1  input  32 each  Addition operands of each requester; stable while its req is high.
- REQ-006 gnt0, gnt1  output  1 each  One-cycle grant pulse; operands were sampled on the edge that raised it.
- REQ-007 add_a, add_b  output  32 each  Operands driven to the shared 32-bit adder.
- REQ-008 add_sum  input  32  Adder sum.
- REQ-009 add_n, add_z, add_c, add_v  input  1 each  Adder flags.
- REQ-010 result  output  32  Registered sum of the last completed operation.
- REQ-011 flags  output  4  Registered {N,Z,C,V} of the last completed operation.
- REQ-012 done  output  1  One-cycle completion pulse.
- REQ-013 done_id  output  1  Requester that owns the current done pulse.
- REQ-014 busy  output  1  High whenever the state is not IDLE.

Function
- REQ-015 The FSM SHALL have exactly three states, IDLE, EXEC and DONE, and SHALL use the encoding IDLE=0.
- REQ-016 In IDLE, if only req0 or only req1 is high, the SHALL grant that requester.
- REQ-017 In IDLE, if both requests are high, the block SHALL grant the requester selected by the priority bit prio.
- REQ-018 On a grant edge the block SHALL register op_a/op_b from the winner's operands, set owner, set gnt<winner>=1 for the next cycle only, and go to EXEC.
- REQ-019 In IDLE with no request, the block SHALL hold every register, and gnt0, gnt1 and done SHALL be 0.
- REQ-020 add_a and add_b SHALL always equal op_a and op_b; there SHALL be no combinational path from a0/b0/a1/b1 to add_a/add_b.
- REQ-021 In EXEC, on the next edge the block SHALL capture result<=add_sum and flags<={add_n,add_z,add_c,add_v}, set done=1 and done_id=owner, and go to DONE.
- REQ-022 In DONE, the block SHALL set prio<=~owner and return to IDLE, and done SHALL deassert on the following edge.
- REQ-023 Latency SHALL be: request seen in IDLE at edge k -> gnt high in cycle k+1 -> done high in cycle k+2 -> IDLE at edge k+3.
- REQ-024 Throughput SHALL be at most one operation per 3 cycles, and a pending request SHALL be granted on the first edge the block is in IDLE.
- REQ-025 Round-robin SHALL guarantee that, with both requests held continuously, grants alternate 0,1,0,1,...
- REQ-026 result and flags SHALL hold their values until the next EXEC->DONE edge and SHALL NOT change on a grant.
- REQ-027 Adder flags SHALL be passed unmodified, including the 32-bit wrap-around case (C=1 and the sum is truncated to 32 bits).
- REQ-028 A request that drops before its grant SHALL be ignored without error, and the other requester SHALL be served normally.
- REQ-029 A grant SHALL NOT be issued to a requester while the state is EXEC or DONE.

Reset
- REQ-030 While rst is high at an edge, the block SHALL set state=IDLE, prio=INIT_PRIO, owner=0, op_a=op_b=0, result=0, flags=4'b0000, gnt0=gnt1=0, done=0, done_id=0 and busy=0.
- REQ-031 rst SHALL override any in-flight EXEC or DONE: the operation SHALL be aborted, no done pulse SHALL be produced, and result/flags SHALL be cleared.
- REQ-032 After rst is released, the first arbitration SHALL use prio=INIT_PRIO.

Verification
- REQ-033 The bench SHALL cover: req0 alone, a0=5, b0=7 -> gnt0 in cycle k+1; done in cycle k+2 with done_id=0, result=12, flags=0000.
- REQ-034 The bench SHALL cover: req0 and req1 both held, INIT_PRIO=0 -> grant order 0,1,0,1, with each done_id matching its owner.
- REQ-035 The bench SHALL cover: a1=0xFFFFFFFF, b1=1 -> result=0, Z=1, C=1.
- REQ-036 The bench SHALL cover: a0=0x7FFFFFFF, b0=1 -> result=0x80000000, V=1, C=0.
- REQ-037 The bench SHALL cover: rst asserted during EXEC -> no done pulse, result=0, state IDLE; a subsequent req1 is granted normally.
- REQ-038 The bench SHALL cover: req0 raised during DONE -> gnt0 on the edge after the return to IDLE; busy is low for exactly one cycle between the two operations.
